// File: rtl/brush_pkg.sv
// rtl/brush_pkg.sv - shared defaults and FSM state type for the brush stamper
package brush_pkg;

   localparam int DEF_H_RES     = 640;
   localparam int DEF_V_RES     = 360;
   localparam int DEF_FB_ADDR_W = 18;
   localparam int DEF_COLOR_W   = 4;

   localparam int X_W = 10;
   localparam int Y_W = 9;
   localparam int R_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/brush_clip.sv
// rtl/brush_clip.sv - clamps the brush centre and clips the square to the framebuffer
module brush_clip
   import brush_pkg::*;
#(
   parameter int H_RES     = DEF_H_RES,
   parameter int V_RES     = DEF_V_RES,
   parameter int FB_ADDR_W = DEF_FB_ADDR_W
) (
   input  logic [X_W-1:0]       i_x,
   input  logic [Y_W-1:0]       i_y,
   input  logic [R_W-1:0]       i_r,
   output logic [X_W-1:0]       o_x0,
   output logic [X_W-1:0]       o_x1,
   output logic [Y_W-1:0]       o_y0,
   output logic [Y_W-1:0]       o_y1,
   output logic [FB_ADDR_W-1:0] o_row_base
);

   localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

   logic [X_W-1:0] w_xc;
   logic [Y_W-1:0] w_yc;
   logic [X_W-1:0] w_rx;
   logic [Y_W-1:0] w_ry;
   logic [X_W:0]   w_xr;
   logic [Y_W:0]   w_yr;

   // Sums carry one extra bit so the upper bound never wraps before clipping.
   always_comb begin
      w_xc = (i_x > X_MAX) ? X_MAX : i_x;
      w_yc = (i_y > Y_MAX) ? Y_MAX : i_y;
      w_rx = X_W'(i_r);
      w_ry = Y_W'(i_r);
      w_xr = {1'b0, w_xc} + {1'b0, w_rx};
      w_yr = {1'b0, w_yc} + {1'b0, w_ry};
      o_x0 = (w_xc >= w_rx) ? (w_xc - w_rx) : '0;
      o_y0 = (w_yc >= w_ry) ? (w_yc - w_ry) : '0;
      o_x1 = (w_xr > {1'b0, X_MAX}) ? X_MAX : w_xr[X_W-1:0];
      o_y1 = (w_yr > {1'b0, Y_MAX}) ? Y_MAX : w_yr[Y_W-1:0];
   end

   generate
      if (H_RES == 640) begin : g_shift_add
         assign o_row_base = (FB_ADDR_W'(o_y0) << 9) + (FB_ADDR_W'(o_y0) << 7);
      end else begin : g_mult
         assign o_row_base = FB_ADDR_W'(o_y0) * FB_ADDR_W'(H_RES);
      end
   endgenerate

endmodule

// File: rtl/brush_stamper.sv
// rtl/brush_stamper.sv - rasterises a clipped square brush into the framebuffer per frame
module brush_stamper
   import brush_pkg::*;
#(
   parameter int H_RES     = DEF_H_RES,
   parameter int V_RES     = DEF_V_RES,
   parameter int FB_ADDR_W = DEF_FB_ADDR_W,
   parameter int COLOR_W   = DEF_COLOR_W
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [X_W-1:0]       cursor_loc_x,
   input  logic [Y_W-1:0]       cursor_loc_y,
   input  logic [COLOR_W-1:0]   cursor_color,
   input  logic [R_W-1:0]       stroke_width,
   input  logic                 pen_down_in,
   input  logic                 nf_in,
   output logic [FB_ADDR_W-1:0] fb_addr_out,
   output logic [COLOR_W-1:0]   fb_data_out,
   output logic                 fb_we_out,
   input  logic                 fb_ready_in,
   output logic                 busy_out,
   output logic                 stamp_done_out
);

   state_t r_state;
   state_t w_next;

   logic [X_W-1:0]       r_x;
   logic [Y_W-1:0]       r_y;
   logic [COLOR_W-1:0]   r_color;
   logic [R_W-1:0]       r_r;
   logic [X_W-1:0]       r_x0;
   logic [X_W-1:0]       r_x1;
   logic [Y_W-1:0]       r_y1;
   logic [X_W-1:0]       r_cx;
   logic [Y_W-1:0]       r_cy;
   logic [FB_ADDR_W-1:0] r_addr;
   logic [FB_ADDR_W-1:0] r_row_step;

   logic [X_W-1:0]       w_x0;
   logic [X_W-1:0]       w_x1;
   logic [Y_W-1:0]       w_y0;
   logic [Y_W-1:0]       w_y1;
   logic [FB_ADDR_W-1:0] w_row_base;
   logic                 w_trigger;
   logic                 w_accept;
   logic                 w_last_col;
   logic                 w_last_pix;

   brush_clip #(
      .H_RES     (H_RES),
      .V_RES     (V_RES),
      .FB_ADDR_W (FB_ADDR_W)
   ) u_clip (
      .i_x        (r_x),
      .i_y        (r_y),
      .i_r        (r_r),
      .o_x0       (w_x0),
      .o_x1       (w_x1),
      .o_y0       (w_y0),
      .o_y1       (w_y1),
      .o_row_base (w_row_base)
   );

   assign w_trigger  = nf_in && pen_down_in;
   assign w_accept   = fb_we_out && fb_ready_in;
   assign w_last_col = (r_cx == r_x1);
   assign w_last_pix = w_last_col && (r_cy == r_y1);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next         = r_state;
      fb_we_out      = 1'b0;
      busy_out       = 1'b1;
      stamp_done_out = 1'b0;
      case (r_state)
         IDLE: begin
            busy_out = 1'b0;
            if (w_trigger) begin
               w_next = SETUP;
            end
         end
         SETUP: begin
            w_next = WRITE;
         end
         WRITE: begin
            fb_we_out = 1'b1;
            if (w_accept && w_last_pix) begin
               w_next = DONE;
            end
         end
         DONE: begin
            stamp_done_out = 1'b1;
            w_next         = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Row step lands on x0 of the next row from x1 of the current one.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_x        <= '0;
         r_y        <= '0;
         r_color    <= '0;
         r_r        <= '0;
         r_x0       <= '0;
         r_x1       <= '0;
         r_y1       <= '0;
         r_cx       <= '0;
         r_cy       <= '0;
         r_addr     <= '0;
         r_row_step <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_trigger) begin
                  r_x     <= cursor_loc_x;
                  r_y     <= cursor_loc_y;
                  r_color <= cursor_color;
                  r_r     <= stroke_width;
               end
            end
            SETUP: begin
               r_x0       <= w_x0;
               r_x1       <= w_x1;
               r_y1       <= w_y1;
               r_cx       <= w_x0;
               r_cy       <= w_y0;
               r_addr     <= w_row_base + FB_ADDR_W'(w_x0);
               r_row_step <= FB_ADDR_W'(H_RES) - FB_ADDR_W'(w_x1 - w_x0);
            end
            WRITE: begin
               if (w_accept && !w_last_pix) begin
                  if (w_last_col) begin
                     r_cx   <= r_x0;
                     r_cy   <= r_cy + 1'b1;
                     r_addr <= r_addr + r_row_step;
                  end else begin
                     r_cx   <= r_cx + 1'b1;
                     r_addr <= r_addr + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign fb_addr_out = r_addr;
   assign fb_data_out = r_color;

endmodule

// File: tb/tb_brush_stamper.sv
// tb/tb_brush_stamper.sv - scoreboard bench for brush_stamper against a pixel-list model
`timescale 1ns/1ps
module tb_brush_stamper;

   logic        clk;
   logic        rst_n;
   logic [9:0]  cursor_x;
   logic [8:0]  cursor_y;
   logic [3:0]  cursor_c;
   logic [2:0]  stroke;
   logic        pen;
   logic        nf;
   logic [17:0] fb_addr;
   logic [3:0]  fb_data;
   logic        fb_we;
   logic        fb_ready;
   logic        busy;
   logic        done;

   brush_stamper dut (
      .clk_in         (clk),
      .rst_in         (rst_n),
      .cursor_loc_x   (cursor_x),
      .cursor_loc_y   (cursor_y),
      .cursor_color   (cursor_c),
      .stroke_width   (stroke),
      .pen_down_in    (pen),
      .nf_in          (nf),
      .fb_addr_out    (fb_addr),
      .fb_data_out    (fb_data),
      .fb_we_out      (fb_we),
      .fb_ready_in    (fb_ready),
      .busy_out       (busy),
      .stamp_done_out (done)
   );

   typedef struct {
      int addr;
      int data;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   done_seen = 0;
   int   exp_done = 0;
   int   ready_mode = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Reference: every pixel of the clamped, clipped square in row-major order.
   task automatic push_expected(input int x, input int y, input int c, input int r);
      int xc, yc, xa, xb, ya, yb;
      xc = (x > 639) ? 639 : x;
      yc = (y > 359) ? 359 : y;
      xa = (xc - r < 0) ? 0 : xc - r;
      xb = (xc + r > 639) ? 639 : xc + r;
      ya = (yc - r < 0) ? 0 : yc - r;
      yb = (yc + r > 359) ? 359 : yc + r;
      for (int yy = ya; yy <= yb; yy++) begin
         for (int xx = xa; xx <= xb; xx++) begin
            exp_t e;
            e.addr = yy * 640 + xx;
            e.data = c;
            q.push_back(e);
         end
      end
   endtask

   // Ready pattern generator; changes just after the rising edge.
   initial begin
      int bcnt;
      bcnt = 0;
      fb_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: fb_ready = ~fb_ready;
            2: fb_ready = 1'($urandom_range(0, 1));
            3: begin
               fb_ready = ((bcnt % 13) >= 10);
               bcnt++;
            end
            default: fb_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every accepted write.
   initial begin
      bit          stall_prev;
      bit          done_prev;
      logic [17:0] hold_addr;
      logic [3:0]  hold_data;
      int          last_acc;
      exp_t        e;
      stall_prev = 0;
      done_prev  = 0;
      last_acc   = -10;
      hold_addr  = '0;
      hold_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 0;
            done_prev  = 0;
         end else begin
            if (stall_prev) begin
               chk("hold_we", fb_we, 1);
               chk("hold_addr", fb_addr, hold_addr);
               chk("hold_data", fb_data, hold_data);
            end
            if (fb_we && fb_ready) begin
               chk("addr_range", fb_addr < 18'd230400, 1);
               if (q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_write: got addr %0d, required no write", fb_addr);
               end else begin
                  e = q.pop_front();
                  chk("wr_addr", fb_addr, e.addr);
                  chk("wr_data", fb_data, e.data);
               end
               last_acc = cyc;
            end
            if (done_prev) chk("busy_after_done", busy, 0);
            if (done) begin
               done_seen++;
               chk("done_latency", cyc, last_acc + 1);
               chk("done_queue_empty", q.size(), 0);
            end
            stall_prev = fb_we && !fb_ready;
            hold_addr  = fb_addr;
            hold_data  = fb_data;
            done_prev  = done;
         end
      end
   end

   task automatic stamp(input int x, input int y, input int c, input int r,
                        input int rmode, input bit extra_nf, input bit do_reset);
      int  d0;
      bit  got;
      ready_mode = rmode;
      d0 = done_seen;
      @(posedge clk);
      #2;
      cursor_x = 10'(x);
      cursor_y = 9'(y);
      cursor_c = 4'(c);
      stroke   = 3'(r);
      pen      = 1'b1;
      nf       = 1'b1;
      push_expected(x, y, c, r);
      @(posedge clk);
      #2;
      nf       = 1'b0;
      cursor_x = 10'($urandom_range(0, 639));
      cursor_y = 9'($urandom_range(0, 359));
      cursor_c = 4'($urandom);
      stroke   = 3'($urandom);
      @(negedge clk);
      chk("setup_busy", busy, 1);
      chk("setup_we", fb_we, 0);
      @(negedge clk);
      chk("first_we", fb_we, 1);
      if (extra_nf) begin
         @(posedge clk);
         #2;
         nf = 1'b1;
         @(posedge clk);
         #2;
         nf = 1'b0;
      end
      if (do_reset) begin
         repeat (3) @(negedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         chk("rst_we", fb_we, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_addr", fb_addr, 0);
         q.delete();
         repeat (2) @(posedge clk);
         #2;
         rst_n = 1'b1;
         repeat (3) @(negedge clk);
         chk("rst_no_done", done_seen, d0);
      end else begin
         exp_done++;
         got = 0;
         for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (done_seen != d0) begin
               got = 1;
               break;
            end
         end
         chk("done_seen", got, 1);
         chk("queue_drained", q.size(), 0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      cursor_x = '0;
      cursor_y = '0;
      cursor_c = '0;
      stroke   = '0;
      pen      = 1'b0;
      nf       = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_addr", fb_addr, 0);
      chk("reset_data", fb_data, 0);
      chk("reset_we", fb_we, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      stamp(320, 180, 5, 0, 0, 0, 0);
      stamp(100, 50, 9, 2, 0, 0, 0);
      stamp(0, 0, 3, 3, 0, 0, 0);
      stamp(638, 359, 7, 1, 0, 0, 0);
      stamp(100, 50, 9, 2, 1, 0, 0);
      stamp(100, 50, 9, 2, 3, 0, 0);
      stamp(1023, 511, 12, 2, 2, 0, 0);
      stamp(200, 200, 4, 3, 0, 1, 0);

      @(posedge clk);
      #2;
      pen = 1'b0;
      nf  = 1'b1;
      @(posedge clk);
      #2;
      nf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("pen_up_busy", busy, 0);
      end

      stamp(300, 100, 6, 4, 0, 0, 1);
      stamp(300, 100, 6, 2, 0, 0, 0);

      for (int k = 0; k < 20; k++) begin
         stamp($urandom_range(0, 700), $urandom_range(0, 400), $urandom_range(0, 15),
               $urandom_range(0, 7), $urandom_range(0, 3), 0, 0);
      end

      pen = 1'b0;
      repeat (20) @(negedge clk);
      chk("done_count", done_seen, exp_done);
      chk("leftover_expected", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
